// File: rtl/vga_timing_detector.sv
// Receive-side 800x600 VGA timing detector: measures hs/vs timing, locks onto a
// stable frame and regenerates pixel position from the incoming syncs.
module vga_timing_detector #(
  parameter int H_ACT_OFF   = 183,
  parameter int H_ACTIVE    = 800,
  parameter int V_ACT_OFF   = 30,
  parameter int V_ACTIVE    = 600,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic        o_locked,
  output logic        o_active,
  output logic [10:0] o_x,
  output logic [9:0]  o_y,
  output logic [10:0] o_line_clks,
  output logic [10:0] o_hs_clks,
  output logic [9:0]  o_frame_lines,
  output logic [9:0]  o_vs_lines,
  output logic        o_frame_start,
  output logic        o_lost
);
  localparam logic [10:0] H_LO   = 11'(H_ACT_OFF);
  localparam logic [10:0] H_HI   = 11'(H_ACT_OFF + H_ACTIVE);
  localparam logic [9:0]  V_LO   = 10'(V_ACT_OFF);
  localparam logic [9:0]  V_HI   = 10'(V_ACT_OFF + V_ACTIVE);
  localparam logic [2:0]  LOCK_N = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state_q;
  logic        hs_prev_q, vs_prev_q, line_seen_q, vs_pend_q;
  logic        locked_q, lost_q, fs_q;
  logic [2:0]  match_cnt_q;
  logic [10:0] h_pos_q, h_pos_d, line_clks_q, line_clks_d, hs_clks_q, hs_clks_d;
  logic [9:0]  v_line_q, v_line_d, vs_cnt_q, vs_cnt_d;
  logic [9:0]  frame_lines_q, frame_lines_d, vs_lines_q, vs_lines_d;
  logic [41:0] snap_q, snap_now;
  logic        line_seen_d, vs_pend_d;
  logic        hs_rise, hs_fall, vs_rise, vs_fall;
  logic        line_tmo, v_sat, fs_evt, match, line_bad;
  logic [10:0] h_pos_p1;
  logic        h_in, v_in;

  assign hs_rise  = i_hs & ~hs_prev_q;
  assign hs_fall  = ~i_hs & hs_prev_q;
  assign vs_rise  = i_vs & ~vs_prev_q;
  assign vs_fall  = ~i_vs & vs_prev_q;
  assign line_tmo = (h_pos_q == 11'h7FF);
  assign v_sat    = (v_line_q == 10'h3FF);
  assign h_pos_p1 = h_pos_q + 11'd1;
  // A vs rise only takes effect at the following hs rise, never the coincident one.
  assign fs_evt   = hs_rise & vs_pend_q;
  assign line_bad = hs_rise & (h_pos_p1 != line_clks_q);

  always_comb begin
    h_pos_d       = line_tmo ? h_pos_q : h_pos_p1;
    v_line_d      = v_line_q;
    line_seen_d   = line_seen_q;
    line_clks_d   = line_clks_q;
    hs_clks_d     = hs_fall ? h_pos_p1 : hs_clks_q;
    frame_lines_d = frame_lines_q;
    vs_lines_d    = vs_lines_q;
    vs_cnt_d      = vs_cnt_q;
    vs_pend_d     = vs_pend_q;
    if (hs_rise) begin
      h_pos_d     = '0;
      line_seen_d = 1'b1;
      if (line_seen_q && !line_tmo) line_clks_d = h_pos_p1;
      if (vs_pend_q) begin
        v_line_d      = '0;
        vs_pend_d     = 1'b0;
        frame_lines_d = v_line_q + 10'd1;
      end else if (!v_sat) begin
        v_line_d = v_line_q + 10'd1;
      end
    end else if (line_tmo) begin
      line_seen_d = 1'b0;
    end
    if (vs_rise) vs_pend_d = 1'b1;
    if (vs_fall) begin
      vs_lines_d = vs_cnt_q;
      vs_cnt_d   = '0;
    end else if (hs_rise && i_vs && vs_cnt_q != 10'h3FF) begin
      vs_cnt_d = vs_cnt_q + 10'd1;
    end
  end

  assign snap_now = {line_clks_d, hs_clks_d, frame_lines_d, vs_lines_d};
  assign match    = (snap_now == snap_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      line_seen_q   <= 1'b0;
      vs_pend_q     <= 1'b0;
      h_pos_q       <= '0;
      v_line_q      <= '0;
      vs_cnt_q      <= '0;
      line_clks_q   <= '0;
      hs_clks_q     <= '0;
      frame_lines_q <= '0;
      vs_lines_q    <= '0;
      snap_q        <= '0;
      fs_q          <= 1'b0;
      lost_q        <= 1'b0;
      locked_q      <= 1'b0;
      match_cnt_q   <= '0;
      state_q       <= SEARCH;
    end else begin
      hs_prev_q     <= i_hs;
      vs_prev_q     <= i_vs;
      line_seen_q   <= line_seen_d;
      vs_pend_q     <= vs_pend_d;
      h_pos_q       <= h_pos_d;
      v_line_q      <= v_line_d;
      vs_cnt_q      <= vs_cnt_d;
      line_clks_q   <= line_clks_d;
      hs_clks_q     <= hs_clks_d;
      frame_lines_q <= frame_lines_d;
      vs_lines_q    <= vs_lines_d;
      fs_q          <= fs_evt;
      lost_q        <= 1'b0;
      if (fs_evt) snap_q <= snap_now;
      case (state_q)
        SEARCH: begin
          if (fs_evt) begin
            state_q     <= TRACK;
            match_cnt_q <= '0;
          end
        end
        TRACK: begin
          if (line_tmo) begin
            state_q <= SEARCH;
          end else if (fs_evt) begin
            if (!match) begin
              match_cnt_q <= '0;
            end else if (match_cnt_q + 3'd1 == LOCK_N) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              match_cnt_q <= match_cnt_q + 3'd1;
            end
          end
        end
        LOCKED: begin
          if (line_tmo || v_sat || line_bad || (fs_evt && !match)) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            lost_q   <= 1'b1;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign h_in          = (h_pos_q >= H_LO) && (h_pos_q < H_HI);
  assign v_in          = (v_line_q >= V_LO) && (v_line_q < V_HI);
  assign o_active      = locked_q & h_in & v_in;
  assign o_x           = o_active ? (h_pos_q - H_LO) : '0;
  assign o_y           = o_active ? (v_line_q - V_LO) : '0;
  assign o_locked      = locked_q;
  assign o_line_clks   = line_clks_q;
  assign o_hs_clks     = hs_clks_q;
  assign o_frame_lines = frame_lines_q;
  assign o_vs_lines    = vs_lines_q;
  assign o_frame_start = fs_q;
  assign o_lost        = lost_q;
endmodule

// File: tb/tb_vga_timing_detector.sv
// Bench for vga_timing_detector: a scaled-down sync source (64 clk lines, 25 line
// frames) plus full-size line timing vectors.
module tb_vga_timing_detector;
  localparam int HAO = 20, HACT = 40, VAO = 6, VACT = 16, LOCKN = 2;

  logic        clk = 1'b0;
  logic        i_rst, i_hs, i_vs;
  logic        o_locked, o_active, o_frame_start, o_lost;
  logic [10:0] o_x, o_line_clks, o_hs_clks;
  logic [9:0]  o_y, o_frame_lines, o_vs_lines;

  always #5 clk = ~clk;

  vga_timing_detector #(
    .H_ACT_OFF(HAO), .H_ACTIVE(HACT), .V_ACT_OFF(VAO), .V_ACTIVE(VACT), .LOCK_FRAMES(LOCKN)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_hs(i_hs), .i_vs(i_vs),
    .o_locked(o_locked), .o_active(o_active), .o_x(o_x), .o_y(o_y),
    .o_line_clks(o_line_clks), .o_hs_clks(o_hs_clks),
    .o_frame_lines(o_frame_lines), .o_vs_lines(o_vs_lines),
    .o_frame_start(o_frame_start), .o_lost(o_lost)
  );

  // Scaled source geometry: hs at 44..51, vs over lines 18..23, active hc<40, vc<16.
  int P = 64, W = 8, HS0 = 44, F = 25, VSL = 6, VS0 = 18;
  int vs_hc = 0, hc = 0, vc = 0, line_extra = 0;
  bit rst_drv = 1'b0;

  int checks = 0, errors = 0;
  int fs_total = 0, lost_total = 0;
  int fs_vc, fs_hc, lost_vc, lost_hc, cur_vc, cur_hc;
  logic fs_locked, fs_lost, lost_locked;

  typedef struct { logic act; logic [10:0] x; logic [9:0] y; } exp_t;
  exp_t sb[$];

  typedef struct { int per; int w; int line; int hsw; } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic hs, input logic vs, input logic rst);
    i_hs = hs; i_vs = vs; i_rst = rst;
    @(posedge clk); #1;
    if (o_frame_start) begin
      fs_total++; fs_locked = o_locked; fs_lost = o_lost; fs_vc = cur_vc; fs_hc = cur_hc;
    end
    if (o_lost) begin
      lost_total++; lost_locked = o_locked; lost_vc = cur_vc; lost_hc = cur_hc;
    end
  endtask

  task automatic drv_step(input bit chk);
    logic hs, vs;
    int pos, vstart;
    exp_t e, g;
    hs = (hc >= HS0) && (hc < HS0 + W);
    pos = vc * P + hc;
    vstart = VS0 * P + vs_hc;
    vs = (pos >= vstart) && (pos < vstart + VSL * P);
    if (chk) begin
      e.act = (vc < VACT) && (hc < HACT);
      e.x = e.act ? 11'(hc) : 11'd0;
      e.y = e.act ? 10'(vc) : 10'd0;
      sb.push_back(e);
    end
    cur_vc = vc; cur_hc = hc;
    cyc(hs, vs, rst_drv);
    if (chk) begin
      g = sb.pop_front();
      check($sformatf("pix v%0d h%0d {act,x,y}", cur_vc, cur_hc),
            {o_active, o_x, o_y}, {g.act, g.x, g.y});
    end
    if (hc == P - 1 + line_extra) begin
      hc = 0; line_extra = 0;
      vc = (vc == F - 1) ? 0 : vc + 1;
    end else begin
      hc++;
    end
  endtask

  task automatic run_until_fs(input int n);
    int start, c;
    start = fs_total; c = 0;
    while (fs_total < start + n && c < n * 2000) begin
      drv_step(1'b0); c++;
    end
    check("frame_start_within_budget", 32'(fs_total >= start + n), 32'd1);
  endtask

  task automatic step_until(input int tv, input int th);
    int c;
    c = 0;
    while (!(vc == tv && hc == th) && c < 2000) begin
      drv_step(1'b0); c++;
    end
    check("position_within_budget", 32'(vc == tv && hc == th), 32'd1);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    hc = 0; vc = 0; line_extra = 0; vs_hc = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_active"}, o_active, 0);
    check({tag, "_x"}, o_x, 0);
    check({tag, "_y"}, o_y, 0);
    check({tag, "_line_clks"}, o_line_clks, 0);
    check({tag, "_hs_clks"}, o_hs_clks, 0);
    check({tag, "_frame_lines"}, o_frame_lines, 0);
    check({tag, "_vs_lines"}, o_vs_lines, 0);
    check({tag, "_frame_start"}, o_frame_start, 0);
    check({tag, "_lost"}, o_lost, 0);
  endtask

  initial begin
    int lost0;
    tbl[0] = '{1041, 120, 1041, 120};
    tbl[1] = '{64,   8,   64,   8};
    tbl[2] = '{100,  1,   100,  1};
    tbl[3] = '{2047, 10,  2047, 10};
    tbl[4] = '{2100, 30,  2047, 30};
    tbl[5] = '{64,   8,   64,   8};

    i_rst = 1'b1; i_hs = 1'b0; i_vs = 1'b0;
    do_reset();
    check_zero("reset");

    // Free-running lines without vs: measurement only, never a frame start.
    for (int i = 0; i < 6; i++) begin
      for (int l = 0; l < 3; l++)
        for (int c = 0; c < tbl[i].per; c++)
          cyc(c < tbl[i].w, 1'b0, 1'b0);
      check($sformatf("vec%0d_line_clks", i), o_line_clks, tbl[i].line);
      check($sformatf("vec%0d_hs_clks", i), o_hs_clks, tbl[i].hsw);
      check($sformatf("vec%0d_locked", i), o_locked, 0);
      check($sformatf("vec%0d_frame_starts", i), fs_total, 0);
    end

    // Initial lock: first frame start leaves SEARCH, then two matching frames.
    do_reset();
    run_until_fs(3);
    check("lock_fs3_locked", fs_locked, 0);
    run_until_fs(1);
    check("lock_fs4_locked", fs_locked, 1);
    check("lock_fs_vc", fs_vc, 18);
    check("lock_fs_hc", fs_hc, 44);
    check("line_clks", o_line_clks, 64);
    check("hs_clks", o_hs_clks, 8);
    check("frame_lines", o_frame_lines, 25);
    check("vs_lines", o_vs_lines, 6);
    for (int i = 0; i < 25 * 64; i++) drv_step(1'b1);
    check("no_lost_while_stable", lost_total, 0);
    check("still_locked", o_locked, 1);

    // One line stretched by a clock.
    step_until(5, 10);
    line_extra = 1;
    lost0 = lost_total;
    for (int c = 0; c < 200 && lost_total == lost0; c++) drv_step(1'b0);
    check("stretch_lost_count", lost_total - lost0, 1);
    check("stretch_lost_vc", lost_vc, 6);
    check("stretch_lost_hc", lost_hc, 44);
    check("stretch_locked_at_lost", lost_locked, 0);
    run_until_fs(2);
    check("stretch_relock_fs2", fs_locked, 0);
    run_until_fs(1);
    check("stretch_relock_fs3", fs_locked, 1);

    // hs held low long enough to saturate the line counter.
    step_until(3, 60);
    lost0 = lost_total;
    for (int c = 0; c < 2100; c++) cyc(1'b0, 1'b0, 1'b0);
    check("timeout_lost_count", lost_total - lost0, 1);
    check("timeout_locked", o_locked, 0);
    check("timeout_line_clks_kept", o_line_clks, 64);
    run_until_fs(2);
    check("timeout_relock_fs2", fs_locked, 0);
    run_until_fs(1);
    check("timeout_relock_fs3", fs_locked, 1);

    // Reset in the middle of an active line.
    step_until(8, 20);
    check("pre_reset_active", o_active, 1);
    check("pre_reset_x", o_x, 19);
    check("pre_reset_y", o_y, 8);
    rst_drv = 1'b1;
    drv_step(1'b0);
    rst_drv = 1'b0;
    check_zero("midreset");
    run_until_fs(3);
    check("reset_relock_fs3", fs_locked, 0);
    run_until_fs(1);
    check("reset_relock_fs4", fs_locked, 1);

    // vs rise coinciding with an hs rise.
    step_until(0, 0);
    vs_hc = HS0;
    run_until_fs(1);
    check("coinc_fs_vc", fs_vc, 19);
    check("coinc_fs_hc", fs_hc, 44);
    check("coinc_frame_lines_first", o_frame_lines, 26);
    check("coinc_lost_on_mismatch", fs_lost, 1);
    run_until_fs(1);
    check("coinc_fs2_vc", fs_vc, 19);
    check("coinc_frame_lines", o_frame_lines, 25);
    check("coinc_vs_lines", o_vs_lines, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
